// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl: single-outstanding load/store bus sequencer with lane alignment, misalignment trap and ack timeout
module lsu_bus_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        mem_write,
    input  logic [2:0]  lw_sw_op,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        req_ready,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] data_mem_read,
    output logic [1:0]  byte_loc,
    output logic        misaligned,
    output logic        timeout,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic we_q, accept, byte_op, half_op, word_op, mis, expire;
    logic [3:0] be_nx;
    logic [31:0] wdata_nx;
    assign accept     = req_valid && state == IDLE;
    assign req_ready  = state == IDLE;
    assign stall      = accept || state == BUS;
    assign resp_valid = state == RESP;
    assign byte_op    = lw_sw_op[1:0] == 2'b00;
    assign half_op    = lw_sw_op[1:0] == 2'b01;
    assign word_op    = lw_sw_op == 3'b010;
    assign mis        = (half_op && addr[0]) || (word_op && addr[1:0] != 2'b00);
    // ack has priority over the expiring counter
    assign expire     = state == BUS && !bus_ack && cnt == CW'(TIMEOUT - 1);
    always_comb begin
        be_nx    = !mem_write ? 4'hf : byte_op ? 4'b0001 << addr[1:0] : half_op ? 4'b0011 << {addr[1], 1'b0} : 4'hf;
        wdata_nx = !mem_write ? '0 : byte_op ? {4{store_data[7:0]}} : half_op ? {2{store_data[15:0]}} : store_data;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        if (accept) state_nx = mis ? RESP : BUS;
        else if (state == BUS && (bus_ack || expire)) state_nx = RESP;
        else if (state == RESP) state_nx = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt           <= '0;
            we_q          <= 1'b0;
            byte_loc      <= 2'b00;
            misaligned    <= 1'b0;
            timeout       <= 1'b0;
            data_mem_read <= '0;
            bus_req       <= 1'b0;
            bus_we        <= 1'b0;
            bus_addr      <= '0;
            bus_wdata     <= '0;
            bus_be        <= '0;
        end else if (accept) begin
            cnt           <= '0;
            we_q          <= mem_write;
            byte_loc      <= addr[1:0];
            misaligned    <= mis;
            timeout       <= 1'b0;
            data_mem_read <= '0;
            if (!mis) begin
                bus_req   <= 1'b1;
                bus_we    <= mem_write;
                bus_addr  <= {addr[31:2], 2'b00};
                bus_wdata <= wdata_nx;
                bus_be    <= be_nx;
            end
        end else if (state == BUS) begin
            cnt     <= cnt + CW'(1);
            timeout <= expire;
            if (bus_ack || expire) begin
                bus_req <= 1'b0;
                bus_we  <= 1'b0;
            end
            if (bus_ack) data_mem_read <= we_q ? '0 : bus_rdata;
        end
endmodule
